// File: rtl/pmod_als_pkg.sv
// Shared constants, FSM state type and result extraction for the PmodALS SPI master.
package pmod_als_pkg;

   localparam int FRAME_BITS = 16;
   localparam int DATA_MSB   = 11;
   localparam int DATA_LSB   = 4;
   localparam int DATA_BITS  = DATA_MSB - DATA_LSB + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } als_state_e;

   function automatic logic [DATA_BITS-1:0] extract_light(input logic [FRAME_BITS-1:0] frame);
      return frame[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/pmod_als_sck_gen.sv
// Free-running SCK divider; strobes mark the HCLK cycle whose edge drives sck high or low.
module pmod_als_sck_gen #(
   parameter int CLK_DIV = 8
) (
   input  logic HCLK,
   input  logic HRESETn,
   output logic sck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic             tick;

   assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
   assign rise_stb = tick & ~sck;
   assign fall_stb = tick & sck;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         div_q <= '0;
         sck   <= 1'b1;
      end else if (tick) begin
         div_q <= '0;
         sck   <= ~sck;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

endmodule

// File: rtl/pmod_als_spi_master.sv
// PmodALS SPI master: frames one 16-bit read per request and strobes the 8-bit light value.
module pmod_als_spi_master
   import pmod_als_pkg::*;
#(
   parameter int CLK_DIV   = 8,
   parameter int GAP_EDGES = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  start,
   output logic                  busy,
   output logic                  valid,
   output logic [DATA_BITS-1:0]  value,
   output logic [FRAME_BITS-1:0] raw,
   output logic                  cs,
   output logic                  sck,
   input  logic                  sdo
);

   localparam int CNT_W = $clog2(FRAME_BITS);
   localparam int GAP_W = (GAP_EDGES > 1) ? $clog2(GAP_EDGES + 1) : 1;

   logic                  rise_stb;
   logic                  fall_stb;
   logic                  sdo_p0;
   logic                  sdo_p1;
   logic [FRAME_BITS-1:0] shift_q;
   logic [FRAME_BITS-1:0] frame_nxt;
   logic [CNT_W-1:0]      bit_cnt;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  pending;
   als_state_e            state_q;
   als_state_e            state_d;
   logic                  accept;
   logic                  sample;
   logic                  last;

   pmod_als_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .sck      (sck),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // stage p0/p1: sdo synchronizer, then shifter loaded on sampling rises
   always_ff @(posedge HCLK) begin
      sdo_p0 <= sdo;
      sdo_p1 <= sdo_p0;
      if (sample) shift_q <= frame_nxt;
   end

   assign frame_nxt = {shift_q[FRAME_BITS-2:0], sdo_p1};
   assign busy      = pending | (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      sample  = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending && rise_stb) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rise_stb) begin
               sample = 1'b1;
               if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                  last    = 1'b1;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (fall_stb && (gap_cnt == GAP_W'(GAP_EDGES - 1))) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         cs      <= 1'b1;
         pending <= 1'b0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         valid   <= 1'b0;
         value   <= '0;
         raw     <= '0;
      end else begin
         state_q <= state_d;
         valid   <= last;
         // a start coinciding with acceptance belongs to the next frame
         if (start) pending <= 1'b1;
         else if (accept) pending <= 1'b0;
         if (accept) begin
            cs      <= 1'b0;
            bit_cnt <= '0;
         end
         if (sample) bit_cnt <= bit_cnt + 1'b1;
         if (last) begin
            cs      <= 1'b1;
            raw     <= frame_nxt;
            value   <= extract_light(frame_nxt);
            gap_cnt <= '0;
         end
         if ((state_q == GAP) && fall_stb) gap_cnt <= gap_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pmod_als_spi_master.sv
// Directed bench for pmod_als_spi_master with a behavioural PmodALS sensor stub.
module tb_pmod_als_spi_master;

   logic        HCLK;
   logic        HRESETn;
   logic        start;
   logic        busy;
   logic        valid;
   logic [7:0]  value;
   logic [15:0] raw;
   logic        cs;
   logic        sck;
   logic        sdo;

   int n_assert = 0;
   int n_fail   = 0;

   pmod_als_spi_master #(
      .CLK_DIV   (4),
      .GAP_EDGES (2)
   ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .start   (start),
      .busy    (busy),
      .valid   (valid),
      .value   (value),
      .raw     (raw),
      .cs      (cs),
      .sck     (sck),
      .sdo     (sdo)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Sensor stub: frame is 4 zeros, 8 data bits, 4 zeros; shifts out on SCK falls with cs low.
   logic [7:0] stub_val;
   int         stub_idx = 0;
   logic [15:0] stub_frame;
   assign stub_frame = {4'b0000, stub_val, 4'b0000};

   initial sdo = 1'b0;
   always @(negedge sck or posedge cs) begin
      if (cs) stub_idx = 0;
      else if (stub_idx < 16) begin
         sdo = stub_frame[15 - stub_idx];
         stub_idx++;
      end
   end

   // Monitor
   int   cyc = 0;
   int   valid_cnt = 0;
   int   valid_wide = 0;
   int   cur_low_falls = 0;
   int   cur_gap_falls = 0;
   int   last_frame_falls = -1;
   int   last_gap_falls = -1;
   int   last_rise = -1;
   int   per_min = 0;
   int   per_max = 0;
   int   cs_low_cyc = 0;
   int   busy_low_cnt = 0;
   logic meas_en = 1'b0;
   logic meas_prev = 1'b0;
   logic busy_watch = 1'b0;
   logic valid_prev = 1'b0;
   logic sck_prev = 1'b1;
   logic cs_prev = 1'b1;

   always @(negedge HCLK) begin
      cyc++;
      if (valid === 1'b1) begin
         valid_cnt++;
         if (valid_prev === 1'b1) valid_wide++;
      end
      valid_prev = valid;
      if (meas_en && !meas_prev) begin
         per_min    = 1000000;
         per_max    = 0;
         cs_low_cyc = 0;
      end
      if (sck_prev && !sck) begin
         if (!cs) cur_low_falls++;
         else cur_gap_falls++;
      end
      if (!sck_prev && sck) begin
         if (meas_en && last_rise >= 0) begin
            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
         end
         last_rise = cyc;
      end
      if (cs_prev && !cs) begin
         last_gap_falls = cur_gap_falls;
         cur_low_falls  = 0;
      end
      if (!cs_prev && cs) begin
         last_frame_falls = cur_low_falls;
         cur_gap_falls    = 0;
      end
      if (meas_en && !cs) cs_low_cyc++;
      if (busy_watch && !busy) busy_low_cnt++;
      meas_prev = meas_en;
      sck_prev  = sck;
      cs_prev   = cs;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int lat);
      int n = 0;
      while (valid !== 1'b1 && n < 400) begin
         @(negedge HCLK);
         n++;
      end
      lat = n;
      check({tag, "_valid_seen"}, 32'(n < 400), 32'd1);
   endtask

   task automatic wait_busy_low(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge HCLK);
         n++;
      end
      check({tag, "_busy_drop"}, 32'(n < 400), 32'd1);
   endtask

   task automatic wait_cs_low(input string tag);
      int n = 0;
      while (cs !== 1'b0 && n < 400) begin
         @(negedge HCLK);
         n++;
      end
      check({tag, "_cs_low"}, 32'(n < 400), 32'd1);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] v);
      int lat;
      stub_val = v;
      pulse_start();
      wait_valid(tag, lat);
      check({tag, "_value"}, 32'(value), 32'(v));
      check({tag, "_raw"}, 32'(raw), 32'({4'b0000, v, 4'b0000}));
      @(negedge HCLK);
   endtask

   initial begin
      int lat;
      int vbase;
      int n;
      HRESETn  = 1'b0;
      start    = 1'b0;
      stub_val = 8'hAB;
      repeat (5) @(negedge HCLK);
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_sck", 32'(sck), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_value", 32'(value), 32'd0);
      check("rst_raw", 32'(raw), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      HRESETn = 1'b1;
      repeat (10) @(negedge HCLK);

      // Single frame from idle
      pulse_start();
      check("ab_busy", 32'(busy), 32'd1);
      wait_valid("ab", lat);
      check("ab_latency_ok", 32'(lat <= 155), 32'd1);
      check("ab_value", 32'(value), 32'hAB);
      check("ab_raw", 32'(raw), 32'h0AB0);
      @(negedge HCLK);
      check("ab_valid_pulse", 32'(valid), 32'd0);
      check("ab_value_hold", 32'(value), 32'hAB);
      wait_busy_low("ab");
      #2;
      check("ab_valid_count", 32'(valid_cnt), 32'd1);
      check("ab_cs_low_periods", 32'(last_frame_falls), 32'd16);

      // Successive frames with distinct patterns
      run_frame("v00", 8'h00);
      wait_busy_low("v00");
      stub_val = 8'hFF;
      pulse_start();
      repeat (20) @(negedge HCLK);
      pulse_start();
      wait_valid("vff", lat);
      check("vff_value", 32'(value), 32'hFF);
      check("vff_raw", 32'(raw), 32'h0FF0);
      stub_val = 8'h5A;
      @(negedge HCLK);
      wait_valid("v5a", lat);
      check("v5a_value", 32'(value), 32'h5A);
      check("v5a_raw", 32'(raw), 32'h05A0);
      wait_busy_low("v5a");
      #2;
      check("gap_edges_ge2", 32'(last_gap_falls >= 2), 32'd1);
      check("v5a_cs_low_periods", 32'(last_frame_falls), 32'd16);

      // Extra start pulses during SHIFT collapse into one more frame
      repeat (5) @(negedge HCLK);
      #2;
      vbase    = valid_cnt;
      stub_val = 8'h3C;
      pulse_start();
      busy_watch = 1'b1;
      wait_cs_low("multi");
      repeat (3) begin
         repeat (4) @(negedge HCLK);
         pulse_start();
      end
      wait_valid("multi1", lat);
      check("multi1_value", 32'(value), 32'h3C);
      @(negedge HCLK);
      wait_valid("multi2", lat);
      check("multi2_value", 32'(value), 32'h3C);
      busy_watch = 1'b0;
      wait_busy_low("multi");
      repeat (300) @(negedge HCLK);
      #2;
      check("multi_busy_held", 32'(busy_low_cnt), 32'd0);
      check("multi_valid_count", 32'(valid_cnt - vbase), 32'd2);
      check("multi_busy_final", 32'(busy), 32'd0);

      // Reset at bit 8 of a frame
      stub_val = 8'hAB;
      vbase    = valid_cnt;
      pulse_start();
      wait_cs_low("rst_mid");
      n = 0;
      while (cur_low_falls < 8 && n < 400) begin
         @(negedge HCLK);
         n++;
      end
      check("rst_mid_reach_bit8", 32'(n < 400), 32'd1);
      HRESETn = 1'b0;
      #1;
      check("rst_mid_cs", 32'(cs), 32'd1);
      check("rst_mid_sck", 32'(sck), 32'd1);
      check("rst_mid_value", 32'(value), 32'd0);
      check("rst_mid_raw", 32'(raw), 32'd0);
      repeat (4) @(negedge HCLK);
      check("rst_mid_valid", 32'(valid), 32'd0);
      HRESETn = 1'b1;
      repeat (200) @(negedge HCLK);
      #2;
      check("rst_mid_no_valid", 32'(valid_cnt - vbase), 32'd0);
      check("rst_mid_value_after", 32'(value), 32'd0);
      run_frame("after_rst", 8'hAB);
      wait_busy_low("after_rst");

      // Idle: no start for 1000 cycles
      repeat (5) @(negedge HCLK);
      #2;
      vbase   = valid_cnt;
      meas_en = 1'b1;
      repeat (1000) @(negedge HCLK);
      meas_en = 1'b0;
      #2;
      check("idle_cs_high", 32'(cs_low_cyc), 32'd0);
      check("idle_sck_per_min", 32'(per_min), 32'd8);
      check("idle_sck_per_max", 32'(per_max), 32'd8);
      check("idle_no_valid", 32'(valid_cnt - vbase), 32'd0);
      check("valid_single_cycle", 32'(valid_wide), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
